// File: rtl/div32_seq_if.sv
// Start/busy/done handshake bundle for the div32_seq iterative divider.
interface div32_seq_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div32_seq.sv
// Iterative 32-bit restoring divider, one quotient bit per clock, trial subtract on cla32.
// Define DIV_SIGNED_EN to honour is_signed (magnitude conversion + sign fix-up in FIX).
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p;
  logic [8:0]  c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;
  assign cout = c[8];

  // 4-bit lookahead groups; group carries chain through G/P
  for (genvar k = 0; k < 8; k++) begin : g_grp
    logic [3:0] gg, pp;
    logic       c1, c2, c3, gp, pg;
    assign gg = g[4*k +: 4];
    assign pp = p[4*k +: 4];
    assign c1 = gg[0] | (pp[0] & c[k]);
    assign c2 = gg[1] | (pp[1] & gg[0]) | (&pp[1:0] & c[k]);
    assign c3 = gg[2] | (pp[2] & gg[1]) | (&pp[2:1] & gg[0]) | (&pp[2:0] & c[k]);
    assign gp = gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0]);
    assign pg = &pp;
    assign c[k+1]      = gp | (pg & c[k]);
    assign sum[4*k +: 4] = pp ^ {c3, c2, c1, c[k]};
  end
endmodule

module div32_seq #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div32_seq_if.slave bus
);
  if (XLEN != 32) begin : g_bad_xlen
    $error("div32_seq: only XLEN=32 is supported");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [31:0] r, r_n, q, q_n, d, d_n, dvd, dvd_n;
  logic [31:0] quo, quo_n, rem, rem_n;
  logic        dz, dz_n, busy_r, busy_n, done_r, done_n, dzo, dzo_n;
  logic [31:0] r_sh, diff, mag_a, mag_b, q_fix, r_fix;
  logic        no_borrow, accept;

  assign accept = (state == IDLE) && bus.start;
  assign r_sh   = {r[30:0], q[31]};

  cla32 u_sub (.a(r_sh), .b(~d), .cin(1'b1), .sum(diff), .cout(no_borrow));

`ifdef DIV_SIGNED_EN
  logic sa, sb, neg_q, neg_r;
  assign sa    = bus.is_signed & bus.dividend[31];
  assign sb    = bus.is_signed & bus.divisor[31];
  assign mag_a = sa ? -bus.dividend : bus.dividend;
  assign mag_b = sb ? -bus.divisor  : bus.divisor;
  // 0x8000_0000 / -1 lands on 0x8000_0000 rem 0 naturally: |a|=2^31, negation wraps
  assign q_fix = neg_q ? -q : q;
  assign r_fix = neg_r ? -r : r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
  end
`else
  assign mag_a = bus.dividend;
  assign mag_b = bus.divisor;
  assign q_fix = q;
  assign r_fix = r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      r      <= '0;
      q      <= '0;
      d      <= '0;
      dvd    <= '0;
      dz     <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dzo    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      r      <= r_n;
      q      <= q_n;
      d      <= d_n;
      dvd    <= dvd_n;
      dz     <= dz_n;
      quo    <= quo_n;
      rem    <= rem_n;
      dzo    <= dzo_n;
      busy_r <= busy_n;
      done_r <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    r_n     = r;
    q_n     = q;
    d_n     = d;
    dvd_n   = dvd;
    dz_n    = dz;
    quo_n   = quo;
    rem_n   = rem;
    dzo_n   = dzo;
    busy_n  = busy_r;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          q_n     = mag_a;
          d_n     = mag_b;
          r_n     = '0;
          cnt_n   = '0;
          dvd_n   = bus.dividend;
          dz_n    = (bus.divisor == 32'd0);
          busy_n  = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        // partial remainder stays below the divisor, so cout alone is the 33-bit compare
        q_n   = {q[30:0], no_borrow};
        r_n   = no_borrow ? diff : r_sh;
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd31) state_n = FIX;
      end
      FIX: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
        if (dz) begin
          quo_n = 32'hFFFF_FFFF;
          rem_n = dvd;
          dzo_n = 1'b1;
        end else begin
          quo_n = q_fix;
          rem_n = r_fix;
          dzo_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quo;
  assign bus.remainder = rem;
  assign bus.div_zero  = dzo;
endmodule
